mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Upstream control stage for mux7to1: drives its 3-bit sel through channels 0..NUM_CH-1.
//  Holds each sel value for DWELL clocks, samples the mux output z at the end of each
//  dwell, and assembles one bit per channel into a result word.
//  Start/busy/done handshake toward the system controller.
// PARAMETERS
//  NUM_CH  7   channels scanned; 1 <= NUM_CH <= 2**SEL_W
//  SEL_W   3   width of sel
//  DWELL   20  clocks per channel, >= 1; z sampled on last dwell clock
// PORTS
//  clk           in   1       rising-edge clock; single clock domain
//  rst_n         in   1       asynchronous, active-low reset
//  start         in   1       scan request, sampled only in IDLE
//  z             in   1       mux7to1 output
//  sel           out  SEL_W   to mux7to1 sel
//  busy          out  1       scan in progress
//  done          out  1       one-clock pulse on scan completion
//  result        out  NUM_CH  bit i = z sampled with sel==i; updated only at completion
//  result_valid  out  1       result holds a complete scan
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sel=0, cnt=0, busy=0, done=0, result=0,
//   result_valid=0, working shift register=0. Applies immediately, including mid-scan.
//  FSM states: IDLE, DWELL, FINISH.
//  IDLE: start=1 at edge k -> DWELL, sel=0, cnt=DWELL-1, busy=1, result_valid=0.
//  DWELL: cnt!=0 -> cnt-1. cnt==0 -> work[sel]<=z.
//   If sel==NUM_CH-1 -> FINISH, result<=work with the new bit merged, busy=0.
//   Otherwise sel+1, cnt=DWELL-1.
//  FINISH: done=1 and result_valid=1 for this cycle; next edge -> IDLE, done=0, sel=0.
//  Latency: start accepted at edge k; last sample at edge k+NUM_CH*DWELL;
//   done high for exactly one cycle after that edge.
//  start while busy or in FINISH: ignored; no queuing.
//  result_valid stays 1 until the next accepted start.
//   result is stable between completions and never shows partial scans.
//  sel changes only on dwell boundaries and never exceeds NUM_CH-1; no wrap to NUM_CH.
//  cnt width = $clog2(DWELL+1). With DWELL=1, sel advances every clock.
//  start held high continuously: new scan begins the cycle after FINISH.
// CONFIGURATION
//  SCAN_CONTINUOUS_EN defined:
//   - FINISH -> DWELL directly with sel=0, cnt=DWELL-1, busy=1.
//   - The start input is not needed after the first scan.
//   - done still pulses once per scan; result_valid stays 1 and result refreshes each scan.
//   - Only reset stops scanning.
//  Not defined: single-shot behaviour as described above.
// TESTING  (DWELL=4, NUM_CH=7 unless noted; bench models mux7to1)
//  1. in0..in6 = 0,1,1,1,0,1,0; pulse start -> sel steps 0..6, 4 clocks each;
//     done 28 clocks after start edge; result = 7'b0101110; result_valid = 1.
//  2. Pulse start again at 10 clocks into a scan -> no effect on sel sequence;
//     done fires once, at clock 28.
//  3. Drop rst_n at clock 13 of a scan (sel=3) -> sel/busy/done/result/result_valid = 0
//     immediately; after release, start gives a full fresh scan.
//  4. DWELL=1: in pattern 1,0,1,0,1,0,1 -> sel changes every clock;
//     done at clock 7; result = 7'b1010101.
//  5. Hold start high -> back-to-back scans with exactly one FINISH cycle between them;
//     result updates only on done.
//  6. SCAN_CONTINUOUS_EN: single start pulse -> done every 29 clocks indefinitely;
//     change in4 to 1 mid-run -> next result = 7'b0111110.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for mux7to1: steps sel through NUM_CH channels, DWELL clocks each, and gathers one z bit per channel.
// Optional macro SCAN_CONTINUOUS_EN: after the first start, scans repeat back-to-back until reset.
module mux_scan_sequencer #(
    parameter int NUM_CH = 7,
    parameter int SEL_W  = 3,
    parameter int DWELL  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              z,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] result,
    output logic              result_valid
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic [NUM_CH-1:0] work_q, work_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            work_q         <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            work_q         <= work_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        work_d         = work_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_DWELL;
                    sel_d          = '0;
                    cnt_d          = CNT_LOAD;
                    busy_d         = 1'b1;
                    result_valid_d = 1'b0;
                    work_d         = '0;
                end
            end

            ST_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    work_d[sel_q] = z;
                    // The merged word goes straight to result so it never exposes a partial scan.
                    if (sel_q == SEL_LAST) begin
                        state_d        = ST_FINISH;
                        result_d       = work_d;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                        cnt_d = CNT_LOAD;
                    end
                end
            end

            ST_FINISH: begin
`ifdef SCAN_CONTINUOUS_EN
                state_d = ST_DWELL;
                sel_d   = '0;
                cnt_d   = CNT_LOAD;
                busy_d  = 1'b1;
                work_d  = '0;
`else
                state_d = ST_IDLE;
                sel_d   = '0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel          = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a DWELL=4 and a DWELL=1 instance, each fed by a modelled mux7to1.
// With SCAN_CONTINUOUS_EN defined the back-to-back scenario is replaced by the continuous-scan scenario.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] in0Vec, in1Vec;
    logic       z0, z1;
    logic [2:0] sel0, sel1;
    logic       busy0, busy1, done0, done1, valid0, valid1;
    logic [6:0] result0, result1;

    int compared   = 0;
    int mismatched = 0;
    int doneAt, doneCnt, n, n2;

    always #5 clk = ~clk;

    // Behavioural mux7to1 in front of each sequencer
    assign z0 = in0Vec[sel0];
    assign z1 = in1Vec[sel1];

    mux_scan_sequencer #(.NUM_CH(7), .SEL_W(3), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .z(z0), .sel(sel0),
        .busy(busy0), .done(done0), .result(result0), .result_valid(valid0)
    );

    mux_scan_sequencer #(.NUM_CH(7), .SEL_W(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .z(z1), .sel(sel1),
        .busy(busy1), .done(done1), .result(result1), .result_valid(valid1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Pulse start on dut0 and watch 40 clocks; optionally re-pulse start at clock midStartAt.
    task automatic runScan4(input int midStartAt, input logic [6:0] expRes,
                            output int firstDone, output int nDone);
        firstDone = -1;
        nDone     = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("scanBusy", busy0, 1);
        checkOutput("scanValidClr", valid0, 0);
        checkOutput("scanSel0", sel0, 0);
        for (int m = 1; m <= 40; m++) begin
            start0 = (m == midStartAt);
            @(posedge clk);
            #1;
            if (m < 28) checkOutput($sformatf("sel@%0d", m), sel0, m / 4);
            if (done0) begin
                nDone++;
                if (firstDone < 0) firstDone = m;
                checkOutput("resAtDone", result0, expRes);
                checkOutput("validAtDone", valid0, 1);
            end
        end
        start0 = 1'b0;
    endtask

    // Count clocks until dut0 raises done; -1 if it never does within the budget.
    task automatic waitDone0(input int budget, output int cnt);
        cnt = -1;
        for (int m = 1; m <= budget; m++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                cnt = m;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : applyStimulus
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        in0Vec = 8'h00;
        in1Vec = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rstSel", sel0, 0);
        checkOutput("rstBusy", busy0, 0);
        checkOutput("rstDone", done0, 0);
        checkOutput("rstResult", result0, 0);
        checkOutput("rstValid", valid0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic scan, pattern 0101110");
        in0Vec = 8'h2E;
        runScan4(0, 7'h2E, doneAt, doneCnt);
        checkOutput("t1DoneAt", doneAt, 28);
        checkOutput("t1DoneCnt", doneCnt, 1);
        checkOutput("t1Result", result0, 7'h2E);
        checkOutput("t1Valid", valid0, 1);
        checkOutput("t1IdleSel", sel0, 0);
        checkOutput("t1IdleBusy", busy0, 0);

        $display("[TB] start while busy is ignored");
        in0Vec = 8'h55;
        runScan4(10, 7'h55, doneAt, doneCnt);
        checkOutput("t2DoneAt", doneAt, 28);
        checkOutput("t2DoneCnt", doneCnt, 1);
        checkOutput("t2Result", result0, 7'h55);

        $display("[TB] asynchronous reset mid-scan");
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checkOutput("t3SelBefore", sel0, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t3Sel", sel0, 0);
        checkOutput("t3Busy", busy0, 0);
        checkOutput("t3Done", done0, 0);
        checkOutput("t3Result", result0, 0);
        checkOutput("t3Valid", valid0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in0Vec = 8'h2E;
        runScan4(0, 7'h2E, doneAt, doneCnt);
        checkOutput("t3FreshDoneAt", doneAt, 28);
        checkOutput("t3FreshResult", result0, 7'h2E);

        $display("[TB] DWELL=1 instance");
        in1Vec = 8'h55;
        doneAt = -1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        checkOutput("t4Sel0", sel1, 0);
        checkOutput("t4Busy", busy1, 1);
        for (int m = 1; m <= 10; m++) begin
            @(posedge clk);
            #1;
            if (m < 7) checkOutput($sformatf("t4Sel@%0d", m), sel1, m);
            if (done1 && doneAt < 0) doneAt = m;
        end
        checkOutput("t4DoneAt", doneAt, 7);
        checkOutput("t4Result", result1, 7'h55);
        checkOutput("t4Valid", valid1, 1);

`ifdef SCAN_CONTINUOUS_EN
        $display("[TB] continuous scanning from one start pulse");
        in0Vec = 8'h2E;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        waitDone0(40, n);
        checkOutput("t6FirstDone", n, 28);
        checkOutput("t6Result1", result0, 7'h2E);
        in0Vec[4] = 1'b1;
        waitDone0(40, n);
        checkOutput("t6Gap1", n, 29);
        checkOutput("t6Result2", result0, 7'h3E);
        waitDone0(40, n);
        checkOutput("t6Gap2", n, 29);
        checkOutput("t6Valid", valid0, 1);
        checkOutput("t6Result3", result0, 7'h3E);
`else
        $display("[TB] start held high gives back-to-back scans");
        in0Vec = 8'h19;
        @(negedge clk);
        start0 = 1'b1;
        waitDone0(40, n);
        checkOutput("t5FirstDone", n, 29);
        checkOutput("t5Result1", result0, 7'h19);
        in0Vec = 8'h66;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t5BusyAgain", busy0, 1);
        checkOutput("t5ResultHeld", result0, 7'h19);
        checkOutput("t5ValidHeld", valid0, 0);
        waitDone0(40, n2);
        checkOutput("t5GapOk", (n2 > 0) && ((15 + n2) == 29 || (15 + n2) == 30), 1);
        checkOutput("t5Result2", result0, 7'h66);
        start0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5DoneOneCycle", done0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
